seq_serializer: RTL

Upstream feeder for the 1011 sequence detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `seq_out`, which drives the detector's serial input directly. A one-word holding register lets a producer stream words back-to-back with no idle bit between them. When no data is pending, the line sits at a fixed idle level.

---
 rtl/seq_serializer_if.sv | 11 +
 rtl/seq_serializer.sv | 106 ++++++++++
 2 files changed

// File: rtl/seq_serializer_if.sv
// Parallel-word handshake between a word producer and seq_serializer.
interface seq_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the 1011 detector: shift register plus a
// one-word holding register so back-to-back words leave no idle bit.
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    seq_serializer_if.slave in_bus,
    input  logic            abort,
    output logic            seq_out,
    output logic            seq_active,
    output logic            last_bit
);

    localparam int unsigned   CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt, sh_shift;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic             seq_out_nxt, seq_active_nxt, last_bit_nxt;
    logic             accept;

    assign in_bus.in_ready = !hold_full && !abort && reset;
    assign accept          = in_bus.in_valid && in_bus.in_ready;
    assign sh_shift        = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

    // Next-state logic; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;

        if (abort) begin
            state_nxt     = S_IDLE;
            cnt_nxt       = '0;
            hold_full_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sh_nxt    = in_bus.in_data;
                        cnt_nxt   = '0;
                        state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt != CNT_LAST) begin
                        sh_nxt  = sh_shift;
                        cnt_nxt = cnt + CW'(1);
                        if (accept) begin
                            hold_nxt      = in_bus.in_data;
                            hold_full_nxt = 1'b1;
                        end
                    end else if (hold_full) begin
                        sh_nxt        = hold;
                        hold_full_nxt = 1'b0;
                        cnt_nxt       = '0;
                    end else if (accept) begin
                        sh_nxt  = in_bus.in_data;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        seq_active_nxt = (state_nxt == S_SHIFT);
        seq_out_nxt    = seq_active_nxt ? (MSB_FIRST ? sh_nxt[WIDTH-1] : sh_nxt[0]) : IDLE_BIT;
        last_bit_nxt   = seq_active_nxt && (cnt_nxt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            sh         <= '0;
            cnt        <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            seq_out    <= IDLE_BIT;
            seq_active <= 1'b0;
            last_bit   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sh         <= sh_nxt;
            cnt        <= cnt_nxt;
            hold       <= hold_nxt;
            hold_full  <= hold_full_nxt;
            seq_out    <= seq_out_nxt;
            seq_active <= seq_active_nxt;
            last_bit   <= last_bit_nxt;
        end
    end

endmodule
